core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler_pkg.sv | 23 ++
 rtl/core_scheduler_if.sv | 27 ++
 rtl/core_scheduler.sv | 74 +++++++
 tb/tb_core_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_scheduler_pkg.sv
// Shared core package: pipeline state encoding broadcast to register files,
// ALUs, LSUs and PC units, plus small helpers used by the scheduler.
package core_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_t;

    localparam int CNT_W = 16;

    // Retired-instruction count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Scheduler bus: fetcher/decoder/LSU/PC-unit inputs and the state broadcast.
interface core_scheduler_if
    import core_scheduler_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
);
    logic               fetch_valid;
    logic               decoded_ret;
    logic [THREADS-1:0] lsu_busy;
    logic [PC_W-1:0]    next_pc;
    core_state_t        core_state;
    logic               fetch_req;
    logic [PC_W-1:0]    current_pc;
    logic [CNT_W-1:0]   instr_count;
    logic               done;

    modport slave (
        input  fetch_valid, decoded_ret, lsu_busy, next_pc,
        output core_state, fetch_req, current_pc, instr_count, done
    );

    modport master (
        output fetch_valid, decoded_ret, lsu_busy, next_pc,
        input  core_state, fetch_req, current_pc, instr_count, done
    );
endinterface

// File: rtl/core_scheduler.sv
// Core scheduler: sequences one instruction at a time through
// FETCH..UPDATE until the decoder reports RET, then parks in DONE.
module core_scheduler
    import core_scheduler_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    core_scheduler_if.slave   bus
);

    core_state_t        state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [THREADS-1:0] lsu_busy;
    logic               any_lsu_busy;

    assign lsu_busy     = bus.lsu_busy;
    assign any_lsu_busy = |lsu_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            FETCH:   if (bus.fetch_valid) state_d = DECODE;
            DECODE:  state_d = REQUEST;
            REQUEST: state_d = WAIT;
            WAIT:    if (!any_lsu_busy) state_d = EXECUTE;
            EXECUTE: state_d = UPDATE;
            UPDATE: begin
                // RET leaves the PC on the returning instruction.
                cnt_d = sat_inc(cnt_q);
                if (bus.decoded_ret) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    pc_d    = bus.next_pc;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.core_state  = state_q;
    assign bus.fetch_req   = (state_q == FETCH);
    assign bus.done        = (state_q == DONE);
    assign bus.current_pc  = pc_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: literal vector table, plan-driven
// directed sequences, an async-reset sequence and randomized instruction streams.
module tb_core_scheduler;

    localparam logic [2:0] S_IDLE = 3'b000, S_FETCH = 3'b001, S_DECODE = 3'b010,
                           S_REQUEST = 3'b011, S_WAIT = 3'b100, S_EXECUTE = 3'b101,
                           S_UPDATE = 3'b110, S_DONE = 3'b111;

    typedef struct {
        logic        st;
        logic        fv;
        logic [3:0]  busy;
        logic        ret;
        logic [7:0]  npc;
        logic [2:0]  e_state;
        logic [7:0]  e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    core_scheduler_if #(.THREADS(4), .PC_W(8)) bus ();

    core_scheduler #(.THREADS(4), .PC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program position kept as plain variables, expected
    // trace built as a queue of per-cycle records from the instruction plan.
    logic [7:0]  m_pc  = 8'h00;
    logic [15:0] m_cnt = 16'h0000;
    bit          noisy = 1'b0;
    vec_t        plan[$];
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [2:0] s, input logic [7:0] pc, input logic [15:0] cnt);
        chk("core_state", 32'(bus.core_state), 32'(s));
        chk("current_pc", 32'(bus.current_pc), 32'(pc));
        chk("instr_count", 32'(bus.instr_count), 32'(cnt));
        chk("fetch_req", 32'(bus.fetch_req), 32'(s == S_FETCH));
        chk("done", 32'(bus.done), 32'(s == S_DONE));
    endtask

    task automatic apply(input vec_t v);
        check_outputs(v.e_state, v.e_pc, v.e_cnt);
        start           = v.st;
        bus.fetch_valid = v.fv;
        bus.lsu_busy    = v.busy;
        bus.decoded_ret = v.ret;
        bus.next_pc     = v.npc;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] s);
        vec_t v;
        v.e_state = s;
        v.e_pc    = m_pc;
        v.e_cnt   = m_cnt;
        if (noisy) begin
            v.st   = 1'($urandom);
            v.fv   = 1'($urandom);
            v.busy = 4'($urandom);
            v.ret  = 1'($urandom);
            v.npc  = 8'($urandom);
        end else begin
            v.st   = 1'b1;
            v.fv   = 1'b1;
            v.busy = 4'h0;
            v.ret  = 1'b0;
            v.npc  = m_pc + 8'd1;
        end
        return v;
    endfunction

    task automatic add_idle(input logic st);
        vec_t v;
        v = mk(S_IDLE);
        v.st = st;
        plan.push_back(v);
    endtask

    task automatic add_instr(input int fdel, input int wbusy, input logic [3:0] bpat,
                             input logic ret, input logic [7:0] npc);
        vec_t v;
        for (int i = 0; i < fdel; i++) begin
            v = mk(S_FETCH); v.fv = 1'b0; plan.push_back(v);
        end
        v = mk(S_FETCH); v.fv = 1'b1; plan.push_back(v);
        plan.push_back(mk(S_DECODE));
        v = mk(S_REQUEST);
        if (wbusy > 0) v.busy = bpat;
        plan.push_back(v);
        for (int i = 0; i < wbusy; i++) begin
            v = mk(S_WAIT); v.busy = bpat; plan.push_back(v);
        end
        v = mk(S_WAIT); v.busy = 4'h0; plan.push_back(v);
        plan.push_back(mk(S_EXECUTE));
        v = mk(S_UPDATE); v.ret = ret; v.npc = npc; plan.push_back(v);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!ret) m_pc = npc;
    endtask

    task automatic add_done(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = mk(S_DONE);
            v.st = 1'($urandom);
            plan.push_back(v);
        end
    endtask

    task automatic run_plan();
        vec_t v;
        while (plan.size() > 0) begin
            v = plan.pop_front();
            apply(v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check_outputs(S_IDLE, 8'h00, 16'h0000);
        @(posedge clk);
        #1;
        chk("reset_hold_state", 32'(bus.core_state), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        m_pc  = 8'h00;
        m_cnt = 16'h0000;
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (bus.core_state !== s && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n < 40), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        bus.fetch_valid = 1'b0;
        bus.decoded_ret = 1'b0;
        bus.lsu_busy    = 4'h0;
        bus.next_pc     = 8'h00;

        tbl[0] = '{1'b0, 1'b1, 4'h0, 1'b0, 8'h01, 3'b000, 8'h00, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b000, 8'h00, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b001, 8'h00, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b010, 8'h00, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b011, 8'h00, 16'd0};
        tbl[5] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b100, 8'h00, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b101, 8'h00, 16'd0};
        tbl[7] = '{1'b1, 1'b1, 4'h0, 1'b0, 8'h01, 3'b110, 8'h00, 16'd0};

        // Basic stream: first instruction from the literal table, then
        // back-to-back instructions, fetch stall, LSU stall, PC wrap, RET.
        do_reset();
        for (int i = 0; i < 8; i++) apply(tbl[i]);
        m_pc  = 8'h01;
        m_cnt = 16'd1;
        noisy = 1'b0;
        add_instr(0, 0, 4'h0, 1'b0, 8'h02);
        add_instr(0, 0, 4'h0, 1'b0, 8'h03);
        add_instr(0, 0, 4'h0, 1'b0, 8'h04);
        add_instr(3, 0, 4'h0, 1'b0, 8'h05);
        add_instr(0, 4, 4'b0100, 1'b0, 8'hFF);
        add_instr(0, 0, 4'h0, 1'b0, 8'h00);
        add_instr(0, 0, 4'h0, 1'b1, 8'h33);
        noisy = 1'b1;
        add_done(4);
        run_plan();
        chk("wrap_ret_pc", 32'(bus.current_pc), 32'h00);
        chk("wrap_ret_cnt", 32'(bus.instr_count), 32'd8);

        // RET on the third instruction, start toggles ignored in DONE.
        do_reset();
        noisy = 1'b0;
        add_idle(1'b1);
        add_instr(0, 0, 4'h0, 1'b0, 8'h01);
        add_instr(0, 0, 4'h0, 1'b0, 8'h02);
        add_instr(0, 0, 4'h0, 1'b1, 8'h77);
        add_done(6);
        run_plan();
        chk("ret3_done", 32'(bus.done), 32'd1);
        chk("ret3_pc", 32'(bus.current_pc), 32'h02);
        chk("ret3_cnt", 32'(bus.instr_count), 32'd3);

        // Asynchronous reset while stalled in WAIT.
        do_reset();
        start = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.lsu_busy    = 4'h0;
        bus.decoded_ret = 1'b0;
        bus.next_pc     = 8'h05;
        wait_state(S_UPDATE, "reach_update");
        bus.lsu_busy = 4'hF;
        wait_state(S_WAIT, "reach_wait");
        @(posedge clk);
        #1;
        chk("wait_stall_state", 32'(bus.core_state), 32'(S_WAIT));
        chk("wait_stall_pc", 32'(bus.current_pc), 32'h05);
        chk("wait_stall_cnt", 32'(bus.instr_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outputs(S_IDLE, 8'h00, 16'h0000);
        bus.lsu_busy = 4'h0;
        @(posedge clk);
        #1;
        chk("reset_mid_state", 32'(bus.core_state), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(S_FETCH, 8'h00, 16'h0000);

        // Randomized instruction streams with noise on every ignored input.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            noisy = 1'b1;
            add_idle(1'b0);
            add_idle(1'b0);
            add_idle(1'b1);
            for (int k = 0; k < 30; k++) begin
                add_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                          4'($urandom_range(1, 15)), (k == 29), 8'($urandom));
            end
            add_done(5);
            run_plan();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
